// File: rtl/alpaca_constants_pkg.sv
// Word-length constants shared by the polyphase FIR datapath.
// The defaults give a 8-bit accumulator (6 frac) feeding 4-bit samples (3 frac).
package alpaca_constants_pkg;
    localparam int WIDTH          = 4;
    localparam int FRAC_WIDTH     = 3;
    localparam int COEFF_WID      = 3;
    localparam int COEFF_FRAC_WID = 3;
    localparam int TUSER_W        = 8;
    localparam int CNT_W          = 16;
endpackage

// File: rtl/alpaca_dtypes_pkg.sv
// Datapath types: multiply-add accumulator, FFT input sample and the
// AXI-stream sideband that rides alongside each word.
package alpaca_dtypes_pkg;
    import alpaca_constants_pkg::*;

    localparam int MAC_W = WIDTH + COEFF_WID + 1;

    typedef logic signed [MAC_W-1:0] mac_t;
    typedef logic signed [WIDTH-1:0] sample_t;

    typedef struct packed {
        logic               tlast;
        logic [TUSER_W-1:0] tuser;
    } side_t;
endpackage

// File: rtl/alpaca_round_sat.sv
// Combinational requantizer halves: round-half-to-even (i_data -> o_k) and
// saturate (i_k -> o_data). The caller places a register between the two.
module alpaca_round_sat #(
    parameter int WI = 8,
    parameter int FI = 6,
    parameter int WO = 4,
    parameter int FO = 3
) (
    input  logic [WI-1:0]       i_data,
    output logic [WI-FI+FO:0]   o_k,
    input  logic [WI-FI+FO:0]   i_k,
    output logic [WO-1:0]       o_data,
    output logic                o_sat
);
    localparam int D  = FI - FO;
    localparam int KW = WI - D + 1;

    if (D < 1) begin : g_bad_drop
        $error("alpaca_round_sat: FI-FO must be at least 1");
    end
    if ((WI - FI) < (WO - FO)) begin : g_bad_int
        $error("alpaca_round_sat: input integer bits narrower than output");
    end
    if (WO < 2) begin : g_bad_wo
        $error("alpaca_round_sat: WO must be at least 2");
    end

    localparam logic [D-1:0]         HALF = D'(1) << (D - 1);
    localparam logic signed [KW-1:0] MAXV = KW'((1 << (WO - 1)) - 1);
    localparam logic signed [KW-1:0] MINV = KW'(-(1 << (WO - 1)));

    logic [KW-1:0] w_trunc;
    logic [D-1:0]  w_rem;
    logic          w_up;

    // One guard bit above the shifted word so the round-up never wraps.
    assign w_trunc = {i_data[WI-1], i_data[WI-1:D]};
    assign w_rem   = i_data[D-1:0];
    assign w_up    = (w_rem > HALF) | ((w_rem == HALF) & w_trunc[0]);
    assign o_k     = w_trunc + KW'(w_up);

    always_comb begin
        o_sat  = 1'b0;
        o_data = i_k[WO-1:0];
        if ($signed(i_k) > MAXV) begin
            o_sat  = 1'b1;
            o_data = {1'b0, {(WO-1){1'b1}}};
        end else if ($signed(i_k) < MINV) begin
            o_sat  = 1'b1;
            o_data = {1'b1, {(WO-1){1'b0}}};
        end
    end
endmodule

// File: rtl/alpaca_requant.sv
// Two-stage AXI-stream requantizer (round, then saturate) between the FIR
// multiply-add and the FFT, with a saturation event counter for the host.
module alpaca_requant
    import alpaca_dtypes_pkg::*;
#(
    parameter int WI      = alpaca_constants_pkg::WIDTH + alpaca_constants_pkg::COEFF_WID + 1,
    parameter int FI      = alpaca_constants_pkg::FRAC_WIDTH + alpaca_constants_pkg::COEFF_FRAC_WID,
    parameter int WO      = alpaca_constants_pkg::WIDTH,
    parameter int FO      = alpaca_constants_pkg::FRAC_WIDTH,
    parameter int TUSER_W = alpaca_constants_pkg::TUSER_W,
    parameter int CNT_W   = alpaca_constants_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WI-1:0]      s_axis_tdata,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic               s_axis_tlast,
    input  logic [TUSER_W-1:0] s_axis_tuser,
    output logic [WO-1:0]      m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    output logic [TUSER_W-1:0] m_axis_tuser,
    input  logic               clr_stats,
    output logic [CNT_W-1:0]   sat_count,
    output logic               ovf
);
    localparam int KW = WI - (FI - FO) + 1;

    if (TUSER_W != $bits(side_t) - 1) begin : g_bad_tuser
        $error("alpaca_requant: TUSER_W must match the sideband struct");
    end

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    logic             r_v1, r_v2;
    logic [KW-1:0]    r_k1;
    side_t            r_side1, r_side2;
    logic [WO-1:0]    r_data2;
    logic             r_sat2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic [KW-1:0]    w_k;
    logic [WO-1:0]    w_sdata;
    logic             w_sat;
    logic             w_ce1, w_ce2, w_acc, w_hs;

    // Assert asynchronously, release two edges after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    alpaca_round_sat #(.WI(WI), .FI(FI), .WO(WO), .FO(FO)) u_round_sat (
        .i_data (s_axis_tdata),
        .o_k    (w_k),
        .i_k    (r_k1),
        .o_data (w_sdata),
        .o_sat  (w_sat)
    );

    assign w_ce2         = !r_v2 | m_axis_tready;
    assign w_ce1         = !r_v1 | w_ce2;
    assign s_axis_tready = w_ce1 & w_rst_n;
    assign w_acc         = s_axis_tvalid & s_axis_tready;
    assign w_hs          = r_v2 & m_axis_tready;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_v1    <= 1'b0;
            r_k1    <= '0;
            r_side1 <= '0;
        end else if (w_ce1) begin
            r_v1 <= w_acc;
            if (w_acc) begin
                r_k1    <= w_k;
                r_side1 <= '{tlast: s_axis_tlast, tuser: s_axis_tuser};
            end
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_v2    <= 1'b0;
            r_data2 <= '0;
            r_sat2  <= 1'b0;
            r_side2 <= '0;
        end else if (w_ce2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_data2 <= w_sdata;
                r_sat2  <= w_sat;
                r_side2 <= r_side1;
            end
        end
    end

    // Clear wins over a same-cycle saturated handshake.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (clr_stats) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_hs & r_sat2) begin
            r_ovf <= 1'b1;
            if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign m_axis_tvalid = r_v2;
    assign m_axis_tdata  = r_data2;
    assign m_axis_tlast  = r_side2.tlast;
    assign m_axis_tuser  = r_side2.tuser;
    assign sat_count     = r_cnt;
    assign ovf           = r_ovf;
endmodule

// File: tb/tb_alpaca_requant.sv
// Directed + randomized bench for alpaca_requant against an arithmetic
// reference (floor divide by 8, round half to even, clamp to [-8,7]).
module tb_alpaca_requant;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [7:0]  s_axis_tuser;
    logic [3:0]  m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [7:0]  m_axis_tuser;
    logic        clr_stats;
    logic [15:0] sat_count;
    logic        ovf;

    always #5 clk = ~clk;

    alpaca_requant dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser),
        .clr_stats(clr_stats), .sat_count(sat_count), .ovf(ovf)
    );

    typedef struct {
        logic [3:0] data;
        bit         sat;
        bit         last;
        logic [7:0] user;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0, checks = 0, cyc = 0, cnt_m = 0, rst_blk = 0;
    bit   ovf_m = 0, chk_lat = 0, prev_stall = 0, last_shs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Value in 1/8 units: round to nearest integer, ties to even, then clamp.
    function automatic void model(input logic [7:0] d, output logic [3:0] y, output bit s);
        int x, k, rem;
        x   = int'($signed(d));
        k   = x >>> 3;
        rem = x - k * 8;
        if (rem > 4 || (rem == 4 && (k & 1) != 0)) k++;
        s = (k > 7) || (k < -8);
        if (k > 7) k = 7;
        if (k < -8) k = -8;
        y = 4'(k);
    endfunction

    task automatic step(input bit vld, input logic [7:0] d, input bit last,
                        input logic [7:0] user, input bit rdy, input bit clr);
        exp_t e;
        bit   m_hs, s_hs, popped_sat;
        @(negedge clk);
        s_axis_tvalid = vld; s_axis_tdata = d; s_axis_tlast = last;
        s_axis_tuser  = user; m_axis_tready = rdy; clr_stats = clr;
        #1;
        chk("sat_count", 32'(sat_count), 32'(cnt_m));
        chk("ovf", 32'(ovf), 32'(ovf_m));
        if (rst_blk > 0) begin
            chk("tready_sync", 32'(s_axis_tready), 32'(0));
            rst_blk--;
        end else begin
            chk("tready", 32'(s_axis_tready), 32'(!(q.size() == 2 && !rdy)));
        end
        if (prev_stall) chk("tvalid_hold", 32'(m_axis_tvalid), 32'(1));
        if (m_axis_tvalid) begin
            chk("unexpected_out", 32'(q.size() > 0), 32'(1));
            if (q.size() > 0) begin
                chk("tdata", 32'(m_axis_tdata), 32'(q[0].data));
                chk("tlast", 32'(m_axis_tlast), 32'(q[0].last));
                chk("tuser", 32'(m_axis_tuser), 32'(q[0].user));
            end
        end
        m_hs = m_axis_tvalid && rdy;
        s_hs = vld && s_axis_tready;
        popped_sat = 0;
        if (m_hs && q.size() > 0) begin
            e = q.pop_front();
            popped_sat = e.sat;
            if (chk_lat) chk("latency", 32'(cyc - e.cyc), 32'(2));
        end
        if (clr) begin
            cnt_m = 0; ovf_m = 0;
        end else if (popped_sat) begin
            ovf_m = 1;
            if (cnt_m < 65535) cnt_m++;
        end
        if (s_hs) begin
            model(d, e.data, e.sat);
            e.last = last; e.user = user; e.cyc = cyc;
            q.push_back(e);
        end
        last_shs   = s_hs;
        prev_stall = m_axis_tvalid && !rdy;
        cyc++;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 50) begin
            step(0, 8'h00, 0, 8'h00, 1, 0);
            n++;
        end
        chk("drain", 32'(q.size()), 32'(0));
        step(0, 8'h00, 0, 8'h00, 1, 0);
    endtask

    // n words, user = index, tlast every 8th; ramp or random data, optional random backpressure.
    task automatic feed(input int n, input bit ramp, input bit bp);
        int         idx = 0, budget = 0;
        logic [7:0] d;
        d = ramp ? 8'h00 : 8'($urandom_range(0, 255));
        while (idx < n && budget < 4000) begin
            step(1, d, (idx % 8) == 7, 8'(idx), bp ? bit'($urandom_range(0, 1)) : 1'b1, 0);
            if (last_shs) begin
                idx++;
                d = ramp ? 8'(idx) : 8'($urandom_range(0, 255));
            end
            budget++;
        end
        chk("feed_budget", 32'(idx), 32'(n));
        drain();
    endtask

    logic [7:0] vec_in  [9];
    logic [3:0] vec_out [9];

    initial begin
        vec_in  = '{8'h04, 8'h0C, 8'h14, 8'h0B, 8'h0D, 8'h7F, 8'h3C, 8'h80, 8'hC4};
        vec_out = '{4'h0,  4'h2,  4'h2,  4'h1,  4'h2,  4'h7,  4'h7,  4'h8,  4'h8};
        rst_n = 0; s_axis_tvalid = 0; s_axis_tdata = 0; s_axis_tlast = 0;
        s_axis_tuser = 0; m_axis_tready = 0; clr_stats = 0;
        #12;
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'(0));
        chk("rst_tdata", 32'(m_axis_tdata), 32'(0));
        chk("rst_tlast", 32'(m_axis_tlast), 32'(0));
        chk("rst_tuser", 32'(m_axis_tuser), 32'(0));
        chk("rst_sat_count", 32'(sat_count), 32'(0));
        chk("rst_ovf", 32'(ovf), 32'(0));
        @(negedge clk); #1; rst_n = 1; rst_blk = 1;
        step(0, 8'h00, 0, 8'h00, 1, 0);

        // Spot-check the reference model itself against hand-worked values.
        for (int i = 0; i < 9; i++) begin
            logic [3:0] y; bit s;
            model(vec_in[i], y, s);
            chk("model_vec", 32'(y), 32'(vec_out[i]));
        end

        // Ties to even, back to back, fixed two-cycle latency
        chk_lat = 1;
        for (int i = 0; i < 5; i++) step(1, vec_in[i], 0, 8'(i), 1, 0);
        drain();
        chk("ties_no_sat", 32'(sat_count), 32'(0));
        // Saturation corners
        for (int i = 5; i < 9; i++) step(1, vec_in[i], 0, 8'(i), 1, 0);
        drain();
        chk_lat = 0;
        chk("sat_count_3", 32'(sat_count), 32'(3));
        chk("ovf_set", 32'(ovf), 32'(1));

        // Ramp under random backpressure, then random data at full rate
        feed(64, 1, 1);
        feed(32, 0, 0);
        feed(40, 0, 1);

        // Clear coinciding with a saturated handshake
        step(1, 8'h7F, 0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 8'h00, 0, 0);
        chk("held_valid", 32'(m_axis_tvalid), 32'(1));
        step(0, 8'h00, 0, 8'h00, 1, 1);
        step(0, 8'h00, 0, 8'h00, 1, 0);
        chk("clr_cnt", 32'(sat_count), 32'(0));
        chk("clr_ovf", 32'(ovf), 32'(0));

        // Counter saturates at all-ones
        for (int i = 0; i < 65535; i++) step(1, 8'h7F, 0, 8'h00, 1, 0);
        drain();
        chk("cnt_max", 32'(sat_count), 32'hFFFF);
        step(1, 8'h80, 0, 8'h00, 1, 0);
        drain();
        chk("cnt_hold", 32'(sat_count), 32'hFFFF);
        chk("cnt_hold_ovf", 32'(ovf), 32'(1));

        // Reset with two words in flight
        step(1, 8'h3C, 1, 8'hAA, 0, 0);
        step(1, 8'h14, 0, 8'hBB, 0, 0);
        chk("two_in_flight", 32'(q.size()), 32'(2));
        #2 rst_n = 0;
        #1;
        chk("async_tvalid", 32'(m_axis_tvalid), 32'(0));
        chk("async_tdata", 32'(m_axis_tdata), 32'(0));
        chk("async_tuser", 32'(m_axis_tuser), 32'(0));
        chk("async_cnt", 32'(sat_count), 32'(0));
        chk("async_ovf", 32'(ovf), 32'(0));
        q.delete(); cnt_m = 0; ovf_m = 0; prev_stall = 0;
        @(negedge clk); #1; rst_n = 1; rst_blk = 1;
        feed(6, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
